// File: rtl/opcode_tag_allocator_pkg.sv
// rtl/opcode_tag_allocator_pkg.sv - shared opcode tag types and pool layout constants
package opcode_tag_allocator_pkg;

  localparam int OPCODE_TAG_W         = 9;
  localparam int OPCODE_NUM_TYPES     = 5;
  localparam int OPCODE_TAGS_PER_TYPE = 64;

  typedef logic [OPCODE_TAG_W-1:0] opcodeTagT;

  typedef enum logic [2:0] {
    OPCODE_A = 3'd0,
    OPCODE_B = 3'd1,
    OPCODE_C = 3'd2,
    OPCODE_D = 3'd3,
    OPCODE_E = 3'd4
  } opcodeEnumT;

  // First tag of each pool in the default layout.
  localparam opcodeTagT OPCODEABASE_A = 9'd0;
  localparam opcodeTagT OPCODEABASE_B = 9'd64;
  localparam opcodeTagT OPCODEABASE_C = 9'd128;
  localparam opcodeTagT OPCODEABASE_D = 9'd192;
  localparam opcodeTagT OPCODEABASE_E = 9'd256;

endpackage

// File: rtl/opcode_tag_allocator_pri_enc.sv
// rtl/opcode_tag_allocator_pri_enc.sv - lowest-set-bit finder used to pick a free tag
module tag_pool_pri_enc
  import opcode_tag_allocator_pkg::*;
#(
  parameter int N     = OPCODE_TAGS_PER_TYPE,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic             found_o,
  output logic [IDX_W-1:0] index_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/opcode_tag_allocator.sv
// rtl/opcode_tag_allocator.sv - per-type tag pools with occupancy tracking, flush and error pulses
module opcode_tag_allocator
  import opcode_tag_allocator_pkg::*;
#(
  parameter int NUM_TYPES     = OPCODE_NUM_TYPES,
  parameter int TAGS_PER_TYPE = OPCODE_TAGS_PER_TYPE,
  parameter int TAG_W         = OPCODE_TAG_W,
  parameter int TYPE_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  input  logic [TYPE_W-1:0]    alloc_type,
  output logic                 alloc_rsp_valid,
  output logic                 alloc_rsp_ok,
  output logic [TAG_W-1:0]     alloc_rsp_tag,
  input  logic                 free_valid,
  input  logic [TAG_W-1:0]     free_tag,
  input  logic                 flush,
  output logic [NUM_TYPES-1:0] type_full,
  output logic [TAG_W:0]       outstanding,
  output logic                 err_range,
  output logic                 err_double_free
);

  localparam int IDX_W = $clog2(TAGS_PER_TYPE);
  localparam int TOTAL = NUM_TYPES * TAGS_PER_TYPE;
  localparam int TF_W  = TAG_W - IDX_W;

  // Reject layouts whose tags cannot be encoded.
  if ((1 << IDX_W) != TAGS_PER_TYPE || TAGS_PER_TYPE < 2) begin : g_bad_depth
    $error("TAGS_PER_TYPE must be a power of 2 and at least 2");
  end
  if (TOTAL > (1 << TAG_W)) begin : g_bad_tag_w
    $error("NUM_TYPES*TAGS_PER_TYPE exceeds the tag space");
  end
  if (TYPE_W < $clog2(NUM_TYPES) || TYPE_W < TF_W) begin : g_bad_type_w
    $error("TYPE_W too narrow for the type field");
  end

  // Bit (type*TAGS_PER_TYPE + index) of the flat bitmap is exactly that tag.
  logic [TOTAL-1:0]     used_q, used_d;
  logic [NUM_TYPES-1:0] type_full_q, type_full_d;
  logic [TAG_W:0]       outstanding_q, outstanding_d;
  logic                 rsp_valid_q, rsp_ok_q;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
  logic                 err_range_q, err_range_d;
  logic                 err_dbl_q, err_dbl_d;

  logic [TAGS_PER_TYPE-1:0] sel_pool;
  logic                     free_found;
  logic [IDX_W-1:0]         free_idx;
  logic                     alloc_type_ok, free_tag_ok, free_bit;
  logic                     grant, do_free;
  logic [TAG_W-1:0]         alloc_tag;

  // Select the requested pool; an out-of-range type looks full so nothing is granted.
  always_comb begin
    sel_pool = '1;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (alloc_type == TYPE_W'(t)) begin
        sel_pool = used_q[t*TAGS_PER_TYPE +: TAGS_PER_TYPE];
      end
    end
  end

  tag_pool_pri_enc #(
    .N     (TAGS_PER_TYPE),
    .IDX_W (IDX_W)
  ) u_pri_enc (
    .req_i   (~sel_pool),
    .found_o (free_found),
    .index_o (free_idx)
  );

  assign alloc_type_ok = int'(alloc_type) < NUM_TYPES;
  assign free_tag_ok   = int'(free_tag) < TOTAL;
  assign free_bit      = used_q[free_tag];
  assign alloc_tag     = {alloc_type[TF_W-1:0], free_idx};

  // Flush wins over both alloc and free; the alloc always sees the pre-free bitmap.
  assign grant   = alloc_valid & alloc_type_ok & ~flush & free_found;
  assign do_free = free_valid & ~flush & free_tag_ok & free_bit;

  // Next-state bitmap, occupancy, response and error pulses.
  always_comb begin
    used_d = used_q;
    if (grant)   used_d[alloc_tag] = 1'b1;
    if (do_free) used_d[free_tag]  = 1'b0;
    if (flush)   used_d = '0;

    type_full_d = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      type_full_d[t] = &used_d[t*TAGS_PER_TYPE +: TAGS_PER_TYPE];
    end

    if (flush) outstanding_d = '0;
    else       outstanding_d = outstanding_q + (TAG_W+1)'(grant) - (TAG_W+1)'(do_free);

    rsp_tag_d   = grant ? alloc_tag : '0;
    err_range_d = (alloc_valid & ~alloc_type_ok) | (free_valid & ~flush & ~free_tag_ok);
    err_dbl_d   = free_valid & ~flush & free_tag_ok & ~free_bit;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      used_q        <= '0;
      type_full_q   <= '0;
      outstanding_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_ok_q      <= 1'b0;
      rsp_tag_q     <= '0;
      err_range_q   <= 1'b0;
      err_dbl_q     <= 1'b0;
    end else begin
      used_q        <= used_d;
      type_full_q   <= type_full_d;
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= alloc_valid;
      rsp_ok_q      <= grant;
      rsp_tag_q     <= rsp_tag_d;
      err_range_q   <= err_range_d;
      err_dbl_q     <= err_dbl_d;
    end
  end

  assign alloc_rsp_valid = rsp_valid_q;
  assign alloc_rsp_ok    = rsp_ok_q;
  assign alloc_rsp_tag   = rsp_tag_q;
  assign type_full       = type_full_q;
  assign outstanding     = outstanding_q;
  assign err_range       = err_range_q;
  assign err_double_free = err_dbl_q;

endmodule

// File: tb/tb_opcode_tag_allocator.sv
// tb/tb_opcode_tag_allocator.sv - scoreboard bench for opcode_tag_allocator
module tb_opcode_tag_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid;
  logic [2:0] alloc_type;
  logic       alloc_rsp_valid;
  logic       alloc_rsp_ok;
  logic [8:0] alloc_rsp_tag;
  logic       free_valid;
  logic [8:0] free_tag;
  logic       flush;
  logic [4:0] type_full;
  logic [9:0] outstanding;
  logic       err_range;
  logic       err_double_free;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int         due;
    logic       ok;
    logic [8:0] tag;
  } rsp_t;

  typedef struct {
    int   due;
    logic er;
    logic df;
  } err_t;

  rsp_t rsp_q[$];
  err_t err_q[$];
  rsp_t mr;
  err_t me;

  opcode_tag_allocator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_valid     (alloc_valid),
    .alloc_type      (alloc_type),
    .alloc_rsp_valid (alloc_rsp_valid),
    .alloc_rsp_ok    (alloc_rsp_ok),
    .alloc_rsp_tag   (alloc_rsp_tag),
    .free_valid      (free_valid),
    .free_tag        (free_tag),
    .flush           (flush),
    .type_full       (type_full),
    .outstanding     (outstanding),
    .err_range       (err_range),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One stimulus cycle; expectations are queued for the monitor, due on the next edge.
  task automatic step(input logic av, input logic [2:0] at, input logic eok, input logic [8:0] etag,
                      input logic fv, input logic [8:0] ft, input logic fl,
                      input logic eer, input logic edf);
    alloc_valid = av;
    alloc_type  = at;
    free_valid  = fv;
    free_tag    = ft;
    flush       = fl;
    if (av) rsp_q.push_back('{cyc + 1, eok, etag});
    err_q.push_back('{cyc + 1, eer, edf});
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic alloc(input logic [2:0] at, input logic eok, input logic [8:0] etag);
    step(1'b1, at, eok, etag, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare responses and error pulses against the scoreboard each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        mr = rsp_q.pop_front();
        chk("rsp_valid", alloc_rsp_valid, 1);
        chk("rsp_ok", alloc_rsp_ok, mr.ok);
        chk("rsp_tag", alloc_rsp_tag, mr.tag);
      end else if (alloc_rsp_valid !== 1'b0) begin
        chk("rsp_unexpected", alloc_rsp_valid, 0);
      end
      if (err_q.size() > 0 && err_q[0].due == cyc) begin
        me = err_q.pop_front();
        chk("err_range", err_range, me.er);
        chk("err_double_free", err_double_free, me.df);
      end else if (err_range !== 1'b0 || err_double_free !== 1'b0) begin
        chk("err_idle", {err_range, err_double_free}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    alloc_type  = '0;
    free_valid  = 1'b0;
    free_tag    = '0;
    flush       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", alloc_rsp_valid, 0);
    chk("reset_rsp_ok", alloc_rsp_ok, 0);
    chk("reset_rsp_tag", alloc_rsp_tag, 0);
    chk("reset_type_full", type_full, 0);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err_range", err_range, 0);
    chk("reset_err_dbl", err_double_free, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // First alloc of type 1 lands at the pool base 64.
    alloc(3'd1, 1'b1, 9'd64);
    chk("outstanding_first", outstanding, 1);

    // Fill pool 4: tags 256..319 in order, then full and refused.
    for (int i = 0; i < 64; i++) alloc(3'd4, 1'b1, 9'(256 + i));
    chk("type_full_pool4", type_full, 5'b10000);
    chk("outstanding_pool4", outstanding, 65);
    alloc(3'd4, 1'b0, 9'd0);
    chk("outstanding_refused", outstanding, 65);

    // Full pool plus same-cycle free: alloc refused, freed tag granted next.
    step(1'b1, 3'd4, 1'b0, 9'd0, 1'b1, 9'd300, 1'b0, 1'b0, 1'b0);
    chk("type_full_after_free", type_full, 0);
    chk("outstanding_after_free", outstanding, 64);
    alloc(3'd4, 1'b1, 9'd300);
    chk("outstanding_net", outstanding, 65);
    chk("type_full_refull", type_full, 5'b10000);

    // Double free and out-of-range free.
    step(1'b0, 3'd0, 1'b0, 9'd0, 1'b1, 9'd5, 1'b0, 1'b0, 1'b1);
    chk("outstanding_dbl_free", outstanding, 65);
    step(1'b0, 3'd0, 1'b0, 9'd0, 1'b1, 9'd400, 1'b0, 1'b1, 1'b0);
    chk("outstanding_range_free", outstanding, 65);

    // Out-of-range alloc type.
    step(1'b1, 3'd7, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);

    // Flush with concurrent alloc and free: alloc refused, free ignored silently.
    step(1'b1, 3'd3, 1'b0, 9'd0, 1'b1, 9'd64, 1'b1, 1'b0, 1'b0);
    chk("flush_outstanding", outstanding, 0);
    chk("flush_type_full", type_full, 0);

    // Ten tags outstanding, then flush with a concurrent alloc.
    for (int i = 0; i < 10; i++) alloc(3'd0, 1'b1, 9'(i));
    chk("outstanding_ten", outstanding, 10);
    step(1'b1, 3'd0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
    chk("flush2_outstanding", outstanding, 0);
    chk("flush2_type_full", type_full, 0);
    alloc(3'd0, 1'b1, 9'd0);
    chk("outstanding_after_flush", outstanding, 1);

    // Three tags live, then reset with an alloc pending.
    alloc(3'd2, 1'b1, 9'd128);
    alloc(3'd2, 1'b1, 9'd129);
    chk("outstanding_three", outstanding, 3);
    alloc_valid = 1'b1;
    alloc_type  = 3'd2;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    chk("midreset_rsp_valid", alloc_rsp_valid, 0);
    chk("midreset_rsp_tag", alloc_rsp_tag, 0);
    chk("midreset_outstanding", outstanding, 0);
    chk("midreset_type_full", type_full, 0);
    rst_n = 1'b1;
    alloc(3'd2, 1'b1, 9'd128);

    // Freeing the tag being granted in the same cycle is a double free.
    step(1'b1, 3'd2, 1'b1, 9'd129, 1'b1, 9'd129, 1'b0, 1'b0, 1'b1);
    chk("outstanding_grant_dbl", outstanding, 2);

    for (int i = 0; i < 10 && (rsp_q.size() > 0 || err_q.size() > 0); i++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opcode_tag_allocator.md
Name: opcode_tag_allocator

Overview:
- Parametrised tag allocator for the opcode-tag space (opcodeTagT).
- Holds NUM_TYPES per-opcode-type tag pools of TAGS_PER_TYPE tags each; tag = type*TAGS_PER_TYPE + index, so with defaults each pool starts at its OPCODEABASE_* value (0, 64, 128, 192, 256).
- Sits between command issue (allocate on issue) and completion (free on retire).
- Generalises the fixed five-type/64-tag layout to any type count and pool depth, and adds occupancy tracking, flush and error detection.

Parameters:
- NUM_TYPES, 5, number of opcode types / pools (matches opcodeEnumT).
- TAGS_PER_TYPE, 64, tags per pool; must be a power of 2.
- TAG_W, 9, tag width (opcodeTagT); NUM_TYPES*TAGS_PER_TYPE <= 2**TAG_W is checked at elaboration.
- TYPE_W, 3, width of the type field; TYPE_W >= clog2(NUM_TYPES) and TYPE_W >= TAG_W-IDX_W (IDX_W = log2(TAGS_PER_TYPE)).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active low
- alloc_valid  in  1  allocate request this cycle
- alloc_type  in  TYPE_W  requested pool (opcodeEnumT value)
- alloc_rsp_valid  out  1  response pulse, one cycle after alloc_valid
- alloc_rsp_ok  out  1  1 = tag granted, 0 = refused
- alloc_rsp_tag  out  TAG_W  granted tag; 0 when refused
- free_valid  in  1  release request
- free_tag  in  TAG_W  tag to release
- flush  in  1  release every tag
- type_full  out  NUM_TYPES  bit t = pool t has no free tag (registered state)
- outstanding  out  TAG_W+1  total tags currently in use
- err_range  out  1  pulse: alloc_type or free_tag type field >= NUM_TYPES
- err_double_free  out  1  pulse: free of a tag not in use

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- State: an in-use bitmap per pool (NUM_TYPES x TAGS_PER_TYPE flops) and an outstanding counter.
- Reset values: all bitmaps 0; outputs alloc_rsp_valid, alloc_rsp_ok, alloc_rsp_tag, type_full, outstanding, err_range and err_double_free all 0.
- Alloc:
  - Latency 1: the response registers update on the edge after alloc_valid.
  - The lowest-index free bit in pool alloc_type is granted and set.
  - alloc_rsp_tag = {alloc_type[TAG_W-IDX_W-1:0], index}.
  - No back-pressure; one request per cycle, back-to-back allowed.
- Alloc refused (alloc_rsp_valid=1, ok=0, tag=0, no state change):
  - pool full;
  - alloc_type >= NUM_TYPES, which also pulses err_range;
  - flush asserted in the same cycle.
- Free:
  - Type field = free_tag[TAG_W-1:IDX_W]; index = free_tag[IDX_W-1:0].
  - Type field >= NUM_TYPES: err_range pulse, no change.
  - Bit already clear: err_double_free pulse, no change.
  - Otherwise the bit clears on the next edge.
- Same-cycle alloc and free, same pool: the alloc uses the pre-free bitmap, so the freed tag is never granted that cycle. A full pool plus a same-cycle free therefore refuses the alloc, and the pool is not full on the next cycle.
- Same-cycle alloc and free of the same just-granted tag is impossible: a bit being granted is clear, so freeing it is a double free.
- outstanding:
  - +1 on a granted alloc; -1 on a valid free; net 0 when both occur.
  - Never wraps; its maximum is NUM_TYPES*TAGS_PER_TYPE.
- type_full[t] = AND of the bits of pool t, registered alongside the bitmap, so it reflects the post-edge state.
- Flush:
  - Priority over alloc and free.
  - Next edge: all bitmaps 0, outstanding 0, type_full 0.
  - The free in a flush cycle is ignored with no error.
- Error pulses last exactly one cycle per offending request. err_range can fire from alloc and free in the same cycle (OR of both).
- Reset mid-operation: any pending response is dropped and all state returns to reset values on the edge.

Decomposition:
- Shared package: opcodeTagT, opcodeEnumT, the OPCODEABASE_* constants, and a new constant OPCODE_TAGS_PER_TYPE = 64.
- Sub-module tag_pool_pri_enc: parametrised lowest-set-bit finder over the inverted pool bitmap, with outputs found and index.
- Instantiated once on the pool selected by a mux over alloc_type.

Test Plan:
- Reset, then alloc type 1 -> next cycle rsp_valid=1, ok=1, tag=64; outstanding=1.
- 64 back-to-back allocs of type 4 -> tags 256..319 in order; type_full[4]=1 after the last; the 65th alloc -> ok=0, tag=0.
- Pool 4 full, then free 300 and alloc type 4 in the same cycle -> refused that cycle; the next alloc of type 4 -> tag=300; outstanding unchanged net.
- Free 5 while tag 5 is unused -> err_double_free one-cycle pulse, outstanding unchanged; free_tag=400 (type field 6) -> err_range pulse.
- alloc_type=7 -> rsp ok=0 plus err_range; flush with 10 tags outstanding and a concurrent alloc -> alloc refused, then outstanding=0 and type_full=0; the next alloc of type 0 -> tag=0.
- Reset asserted mid-run with 3 tags allocated -> all outputs 0 next cycle; the next alloc of type 2 -> tag=128.
